// File: rtl/verification_engine.sv
// Responder for the controller's verification request: latches user and
// reference codes, compares one digit per clock, then holds the verdict.
module verification_engine #(
    parameter int N_DIGITS  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_DIGIT = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [N_DIGITS*DIGIT_W-1:0]       user_code,
    input  logic [N_DIGITS*DIGIT_W-1:0]       ref_code,
    output logic                              busy,
    output logic                              final_analysis,
    output logic                              match,
    output logic [$clog2(N_DIGITS+1)-1:0]     mismatch_count,
    output logic                              invalid_digit
);

    localparam int CODE_W = N_DIGITS * DIGIT_W;
    localparam int CW     = $clog2(N_DIGITS + 1);
    localparam int IW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0]      IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);

    typedef enum logic [1:0] {IDLE, COMPARE, REPORT} state_t;

    state_t              state_q;
    logic [CODE_W-1:0]   user_q, ref_q;
    logic [IW-1:0]       idx_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                inv_q, inv_d;
    logic                busy_q, fa_q, match_q;
    logic [DIGIT_W-1:0]  ud, rd;

    // Running totals including the digit under the index this cycle.
    always_comb begin
        ud    = user_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
        rd    = ref_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
        cnt_d = cnt_q + CW'(ud != rd);
        inv_d = inv_q | (ud > MAX_D);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            user_q  <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            fa_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        user_q  <= user_code;
                        ref_q   <= ref_code;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        inv_q   <= 1'b0;
                        match_q <= 1'b0;
                        fa_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (!start) begin
                        // Controller withdrew the request: abort without a verdict.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        inv_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        inv_q <= inv_d;
                        if (idx_q == IDX_LAST) begin
                            state_q <= REPORT;
                            busy_q  <= 1'b0;
                            fa_q    <= 1'b1;
                            match_q <= (cnt_d == '0) && !inv_d;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                REPORT: begin
                    if (!start) begin
                        state_q <= IDLE;
                        fa_q    <= 1'b0;
                        match_q <= 1'b0;
                        cnt_q   <= '0;
                        inv_q   <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign final_analysis = fa_q;
    assign match          = match_q;
    assign mismatch_count = cnt_q;
    assign invalid_digit  = inv_q;

endmodule

// File: tb/tb_verification_engine.sv
// Scoreboard bench for verification_engine: directed plan cases plus random
// runs, with verdicts checked by a decoupled monitor against a digit model.
module tb_verification_engine;

    localparam int N = 4;
    localparam int W = 4;

    typedef struct packed {
        logic       m;
        logic [2:0] cnt;
        logic       inv;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  user_code = '0;
    logic [15:0]  ref_code = '0;
    logic         busy, final_analysis, match, invalid_digit;
    logic [2:0]   mismatch_count;

    int   vecs = 0;
    int   errs = 0;
    exp_t sb[$];
    logic fa_prev = 1'b0;

    verification_engine #(.N_DIGITS(N), .DIGIT_W(W), .MAX_DIGIT(9)) dut (
        .clk(clk), .rst(rst), .start(start), .user_code(user_code),
        .ref_code(ref_code), .busy(busy), .final_analysis(final_analysis),
        .match(match), .mismatch_count(mismatch_count),
        .invalid_digit(invalid_digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count differing digit positions and any user digit above 9.
    function automatic exp_t model(input logic [15:0] u, input logic [15:0] r);
        exp_t e;
        int   c = 0;
        bit   bad = 0;
        for (int i = 0; i < N; i++) begin
            int ud = int'((u >> (i * W)) & 16'hF);
            int rd = int'((r >> (i * W)) & 16'hF);
            if (ud != rd) c++;
            if (ud > 9) bad = 1;
        end
        e.cnt = 3'(c);
        e.inv = bad;
        e.m   = (c == 0) && !bad;
        return e;
    endfunction

    // Monitor: every rising verdict consumes one scoreboard entry.
    always @(negedge clk) begin
        if (final_analysis && !fa_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_verdict", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("match", {31'd0, match}, {31'd0, e.m});
                chk("mismatch_count", {29'd0, mismatch_count}, {29'd0, e.cnt});
                chk("invalid_digit", {31'd0, invalid_digit}, {31'd0, e.inv});
            end
        end
        fa_prev = final_analysis;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_fa"}, {31'd0, final_analysis}, 32'd0);
        chk({name, "_match"}, {31'd0, match}, 32'd0);
        chk({name, "_cnt"}, {29'd0, mismatch_count}, 32'd0);
        chk({name, "_inv"}, {31'd0, invalid_digit}, 32'd0);
    endtask

    // One full run; chg overwrites user_code after the latch edge.
    task automatic run(input logic [15:0] u, input logic [15:0] r, input bit chg, input int hold);
        user_code = u;
        ref_code  = r;
        start     = 1'b1;
        sb.push_back(model(u, r));
        for (int i = 0; i < N; i++) begin
            tick();
            if (chg && i == 0) user_code = 16'h0000;
            chk("busy_compare", {31'd0, busy}, 32'd1);
            chk("fa_early", {31'd0, final_analysis}, 32'd0);
        end
        tick();
        chk("verdict_latency", {31'd0, final_analysis}, 32'd1);
        chk("busy_report", {31'd0, busy}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_fa", {31'd0, final_analysis}, 32'd1);
            chk("hold_busy", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;
        tick();
        chk_idle("release");
    endtask

    initial begin
        #2;
        chk_idle("reset");
        tick();
        rst = 1'b0;
        tick();

        run(16'h1234, 16'h1234, 0, 2);
        run(16'h1294, 16'h1234, 0, 0);
        run(16'h4321, 16'h1234, 0, 0);
        run(16'h12A4, 16'h12A4, 0, 1);
        run(16'h1234, 16'h1234, 1, 0);

        // Abort after two compare cycles.
        user_code = 16'h5555; ref_code = 16'h5555; start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        tick();
        chk_idle("abort");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_fa", {31'd0, final_analysis}, 32'd0);
        end

        // Long hold, then one low edge and an immediate fresh run.
        run(16'h9876, 16'h9870, 0, 10);
        run(16'hF0F0, 16'h0F0F, 0, 0);

        // Asynchronous reset mid-compare clears outputs before the next edge.
        user_code = 16'h1111; ref_code = 16'h2222; start = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_idle("post_rst");

        for (int k = 0; k < 30; k++) begin
            logic [15:0] r, u;
            for (int i = 0; i < N; i++) begin
                r[i*W +: W] = 4'($urandom_range(0, 9));
                case ($urandom_range(0, 3))
                    0, 1:    u[i*W +: W] = r[i*W +: W];
                    2:       u[i*W +: W] = 4'($urandom_range(0, 9));
                    default: u[i*W +: W] = 4'($urandom_range(0, 15));
                endcase
            end
            run(u, r, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
        end

        tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
